regfile_mp: RTL
===============

# regfile_mp

Parametrised multi-port register file, successor to the fixed 32x32 two-read-port register file in the multi-cycle CPU datapath. It provides a configurable width, depth and number of read ports, byte-strobed writes and optional write-to-read bypass. A sequential clear engine zeroes the array after reset or on request and signals `ready`. The CPU control unit stalls on `ready` low.

## Interface
- `DATA_W`, default 32: data width; must be a multiple of 8.
- `ADDR_W`, default 5: address width; DEPTH = 2**ADDR_W.
- `NRD`, default 2: number of read ports, 1..4.
- `BYPASS`, default 1: 1 = same-cycle write data forwarded to matching read ports.
- `ZERO_R0`, default 1: 1 = entry 0 is hardwired to zero (reads 0, writes dropped).

- `clk`  in  1  clock; all state changes on its rising edge.
- `resetn`  in  1  reset; one clock, reset is synchronous and active-low.
- `ready`  out  1  high = array valid, writes accepted.
- `clr_req`  in  1  single-cycle request to re-zero the whole array.
- `wen`  in  1  write enable.
- `waddr`  in  ADDR_W  write address.
- `wdata`  in  DATA_W  write data.
- `wstrb`  in  DATA_W/8  byte enables; bit b covers `wdata[8b+7:8b]`.
- `wr_drop`  out  1  registered one-cycle pulse: a write with `wen`=1 was discarded.
- `raddr`  in  NRD*ADDR_W  packed read addresses; port i uses slice i.
- `rdata`  out  NRD*DATA_W  packed read data; combinational.
- `test_addr`  in  ADDR_W  debug read address.
- `test_data`  out  DATA_W  debug read data; combinational, never bypassed.

## Operation
- **States.** CLEAR and RUN. A clear counter `ctr` is ADDR_W bits wide.
- **Reset.** While `resetn`=0 at an edge: state <= CLEAR, `ctr` <= 0, `ready` <= 0, `wr_drop` <= 0. The array itself is not reset directly, so it remains RAM-inferable.
- **CLEAR.**
  - Each edge writes 0 to `rf[ctr]` and increments `ctr`.
  - At the edge where `ctr`==DEPTH-1: state <= RUN and `ready` <= 1.
  - `wen` is ignored; every ignored write with `wen`=1 produces `wr_drop`.
  - `clr_req` is ignored; the sweep is not restarted.
  - All `rdata` and `test_data` outputs are forced to 0.
- **RUN.**
  - `clr_req`=1: state <= CLEAR, `ctr` <= 0, `ready` <= 0. Any write in that same cycle is dropped and `wr_drop` pulses (clear has priority).
  - Otherwise, with `wen`=1: each byte b where `wstrb[b]`=1 is written into `rf[waddr]`; the other bytes are kept.
  - With ZERO_R0=1 and `waddr`==0: the write is silently discarded. This is not a drop; `wr_drop` stays 0.
  - `wen`=1 with `wstrb`=0: no change, no drop.
- **Reads.**
  - Port i returns `rf[raddr_i]`, or 0 when ZERO_R0=1 and `raddr_i`==0.
  - With BYPASS=1, state RUN, `wen`=1, `clr_req`=0, `waddr`==`raddr_i` and the address not zeroed: port i returns the strobe-merged value, i.e. new bytes where `wstrb` is set and stored bytes elsewhere.
- **Overlap.** Any number of read ports may address the same entry.

## Timing
- Read latency: 0 cycles (combinational from address).
- Write visibility:
  - BYPASS=1: in the same cycle on the read ports.
  - BYPASS=0: from the cycle after the write edge.
  - `test_data`: from the next cycle in either case.
- Clear duration: `ready` rises exactly DEPTH edges after the first edge sampled with `resetn`=1 (32 cycles at defaults). A `clr_req` clear also takes DEPTH edges.
- `wr_drop` asserts on the edge after the dropped request and lasts one cycle per dropped write.
- Reset asserted mid-clear restarts the sweep at `ctr`=0. Reset asserted in RUN leaves the array contents stale until the sweep overwrites them, and reads return 0 meanwhile.
- Reset values: `ready`=0, `wr_drop`=0, `rdata`=0, `test_data`=0.

## Structure
- Package `regfile_mp_pkg` holds:
  - the state enum (CLEAR, RUN);
  - the function computing the byte-strobe merge.
- Sub-module `regfile_rd_port` implements one read port: zero-register check, bypass compare, merge mux and CLEAR forcing. The top level instantiates it NRD times with a generate loop.
- The top level holds the array, the write logic, the clear FSM and the test port.

## Test plan
- **Reset release.** Hold `resetn`=0 for 3 cycles, then release. Expect `ready`=0 for 32 cycles and `ready`=1 on the 32nd edge; reading every address returns 0.
- **Byte-strobed write.** In RUN: write 0xDEADBEEF to r5 with `wstrb`=0xF, then 0x11223344 to r5 with `wstrb`=0x5. The next cycle r5 reads 0xDE22BE44. A write to r0 leaves r0 = 0 and `wr_drop`=0.
- **Bypass.** BYPASS=1, r7=0xAAAA5555. In the same cycle write `wdata`=0x12345678 to r7 with `wstrb`=0x3, with `raddr0`=`raddr1`=7. Both ports show 0xAAAA5678 in that cycle; `test_data`(7) shows the old value until the next cycle. Repeat with BYPASS=0: the old value is shown until the next cycle.
- **Clear request.** In RUN with nonzero data, assert `clr_req` together with `wen` to r3. Expect `wr_drop` for one cycle, `ready`=0 for 32 cycles, r3=0 afterward and reads forced to 0 during the clear.
- **Reset mid-clear.** Assert `resetn`=0 at clear cycle 10. Expect the sweep to restart and `ready` to rise 32 edges after release. A `clr_req` during CLEAR is ignored and does not extend the clear.
- **Parametrisation.** DATA_W=64, ADDR_W=3, NRD=4, ZERO_R0=0. Expect an 8-cycle clear, r0 to be writable, and four ports reading distinct entries concurrently.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared types and helpers for the multi-port register file.
//   state_e     : clear-engine state (StClear sweeps the array, StRun is normal operation)
//   merge_bytes : byte-strobe merge of new data over a stored word
package regfile_mp_pkg;

   typedef enum logic {StClear, StRun} state_e;

   // Widest word the merge helper handles; callers zero-extend and truncate.
   localparam int unsigned MaxW = 256;
   localparam int unsigned MaxB = MaxW / 8;

   function automatic logic [MaxW-1:0] merge_bytes(input logic [MaxW-1:0] old_val,
                                                   input logic [MaxW-1:0] new_val,
                                                   input logic [MaxB-1:0] strb);
      logic [MaxW-1:0] res;
      res = old_val;
      for (int b = 0; b < int'(MaxB); b++) begin
         if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: bus bundle of the multi-port register file.
//   master (CPU side) drives clr_req, wen, waddr, wdata, wstrb, raddr, test_addr
//   slave  (regfile)  drives ready, wr_drop, rdata, test_data
// raddr/rdata are packed, port i uses slice i.
interface regfile_mp_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned NRD    = 2
);
   logic                    ready;
   logic                    clr_req;
   logic                    wen;
   logic [ADDR_W-1:0]       waddr;
   logic [DATA_W-1:0]       wdata;
   logic [DATA_W/8-1:0]     wstrb;
   logic                    wr_drop;
   logic [NRD*ADDR_W-1:0]   raddr;
   logic [NRD*DATA_W-1:0]   rdata;
   logic [ADDR_W-1:0]       test_addr;
   logic [DATA_W-1:0]       test_data;

   modport master (
      input  ready, wr_drop, rdata, test_data,
      output clr_req, wen, waddr, wdata, wstrb, raddr, test_addr
   );

   modport slave (
      output ready, wr_drop, rdata, test_data,
      input  clr_req, wen, waddr, wdata, wstrb, raddr, test_addr
   );
endinterface

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one combinational read port.
//   run    : array valid; outputs are forced to 0 while clearing
//   byp_en : a live write is happening this cycle (RUN, wen, no clr_req)
//   raddr  : read address          stored : rf[raddr] from the array
//   waddr/wdata/wstrb : current write, used for same-cycle forwarding
//   rdata  : read result
module regfile_rd_port
   import regfile_mp_pkg::*;
#(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ADDR_W  = 5,
   parameter int unsigned BYPASS  = 1,
   parameter int unsigned ZERO_R0 = 1
) (
   input  logic                run,
   input  logic                byp_en,
   input  logic [ADDR_W-1:0]   raddr,
   input  logic [DATA_W-1:0]   stored,
   input  logic [ADDR_W-1:0]   waddr,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   output logic [DATA_W-1:0]   rdata
);

   logic [DATA_W-1:0] merged;
   assign merged = DATA_W'(merge_bytes(MaxW'(stored), MaxW'(wdata), MaxB'(wstrb)));

   always_comb begin
      rdata = '0;
      if (!run) begin
         rdata = '0;
      end else if ((ZERO_R0 != 0) && (raddr == '0)) begin
         rdata = '0;
      end else if ((BYPASS != 0) && byp_en && (waddr == raddr)) begin
         rdata = merged;
      end else begin
         rdata = stored;
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with byte-strobed writes,
// optional write-to-read bypass and a sequential clear engine.
//   clk, resetn : clock, synchronous active-low reset
//   bus (slave) : ready, clr_req, wen/waddr/wdata/wstrb, wr_drop,
//                 raddr/rdata (NRD packed ports), test_addr/test_data (unbypassed)
module regfile_mp
   import regfile_mp_pkg::*;
#(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ADDR_W  = 5,
   parameter int unsigned NRD     = 2,
   parameter int unsigned BYPASS  = 1,
   parameter int unsigned ZERO_R0 = 1
) (
   input logic          clk,
   input logic          resetn,
   regfile_mp_if.slave  bus
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   state_e            state_q;
   logic [ADDR_W-1:0] ctr_q;
   logic              ready_q;
   logic              wr_drop_q;

   logic [DATA_W-1:0] rf [DEPTH];

   logic              run;
   logic              wr_live;
   logic              wr_do;
   logic              drop;
   logic [DATA_W-1:0] wr_merged;

   assign run     = (state_q == StRun);
   // clr_req wins over a write in the same cycle
   assign wr_live = run && bus.wen && !bus.clr_req;
   // writes to a hardwired r0 are discarded silently, not counted as drops
   assign wr_do   = wr_live && !((ZERO_R0 != 0) && (bus.waddr == '0)) && (|bus.wstrb);
   assign drop    = bus.wen && (!run || bus.clr_req);
   assign wr_merged = DATA_W'(merge_bytes(MaxW'(rf[bus.waddr]), MaxW'(bus.wdata),
                                          MaxB'(bus.wstrb)));

   // Array has no reset so it stays RAM-inferable; the sweep zeroes it instead.
   always_ff @(posedge clk) begin
      if (!run) begin
         rf[ctr_q] <= '0;
      end else if (wr_do && resetn) begin
         rf[bus.waddr] <= wr_merged;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= StClear;
         ctr_q     <= '0;
         ready_q   <= 1'b0;
         wr_drop_q <= 1'b0;
      end else begin
         wr_drop_q <= drop;
         case (state_q)
            StClear: begin
               ctr_q <= ctr_q + 1'b1;
               if (ctr_q == ADDR_W'(DEPTH - 1)) begin
                  state_q <= StRun;
                  ready_q <= 1'b1;
               end
            end
            StRun: begin
               if (bus.clr_req) begin
                  state_q <= StClear;
                  ctr_q   <= '0;
                  ready_q <= 1'b0;
               end
            end
            default: begin
               state_q <= StClear;
               ctr_q   <= '0;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ready   = ready_q;
   assign bus.wr_drop = wr_drop_q;

   always_comb begin
      bus.test_data = '0;
      if (run && !((ZERO_R0 != 0) && (bus.test_addr == '0))) begin
         bus.test_data = rf[bus.test_addr];
      end
   end

   logic [ADDR_W-1:0] ra [NRD];
   logic [DATA_W-1:0] rd [NRD];

   for (genvar i = 0; i < int'(NRD); i++) begin : g_rd
      assign ra[i] = bus.raddr[i*ADDR_W +: ADDR_W];

      regfile_rd_port #(
         .DATA_W  (DATA_W),
         .ADDR_W  (ADDR_W),
         .BYPASS  (BYPASS),
         .ZERO_R0 (ZERO_R0)
      ) u_rd_port (
         .run    (run),
         .byp_en (wr_live),
         .raddr  (ra[i]),
         .stored (rf[ra[i]]),
         .waddr  (bus.waddr),
         .wdata  (bus.wdata),
         .wstrb  (bus.wstrb),
         .rdata  (rd[i])
      );
   end

   always_comb begin
      bus.rdata = '0;
      for (int i = 0; i < int'(NRD); i++) begin
         bus.rdata[i*DATA_W +: DATA_W] = rd[i];
      end
   end

endmodule
